// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer for a pipeline stage boundary, with exception blocking
// (first excepting entry blocks all later entries until flush) and flush support.
module pipe_stage_buf #(
  parameter int DATA_W     = 160,
  parameter int EXC_W      = 5,
  parameter int EXC_CODE_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [EXC_W-1:0]      in_exc,
  input  logic                  in_ds,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [EXC_W-1:0]      out_exc,
  output logic                  out_ds,
  output logic                  out_exc_any,
  output logic [EXC_CODE_W-1:0] out_exc_code,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [EXC_W-1:0]    main_exc_q, main_exc_d, skid_exc_q, skid_exc_d;
  logic                main_ds_q, main_ds_d, skid_ds_q, skid_ds_d;
  logic                exc_blk_q, exc_blk_d;

  logic                main_vld, skid_vld;
  logic                in_xfer, out_xfer, accept;

  assign main_vld  = (state_q != EMPTY);
  assign skid_vld  = (state_q == TWO);
  assign occupancy = state_q;

  // Both terms are registers, so out_ready never reaches in_ready.
  assign in_ready  = ~skid_vld | exc_blk_q;
  assign out_valid = main_vld;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign accept   = in_xfer & ~exc_blk_q & ~flush;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_exc_d  = main_exc_q;
    main_ds_d   = main_ds_q;
    skid_data_d = skid_data_q;
    skid_exc_d  = skid_exc_q;
    skid_ds_d   = skid_ds_q;
    exc_blk_d   = exc_blk_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_data_d = in_data;
          main_exc_d  = in_exc;
          main_ds_d   = in_ds;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && out_xfer) begin
          main_data_d = in_data;
          main_exc_d  = in_exc;
          main_ds_d   = in_ds;
        end else if (accept) begin
          skid_data_d = in_data;
          skid_exc_d  = in_exc;
          skid_ds_d   = in_ds;
          state_d     = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_exc_d  = skid_exc_q;
          main_ds_d   = skid_ds_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (accept && (|in_exc)) exc_blk_d = 1'b1;

    if (flush) begin
      state_d   = EMPTY;
      exc_blk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_exc_q  <= '0;
      main_ds_q   <= 1'b0;
      skid_data_q <= '0;
      skid_exc_q  <= '0;
      skid_ds_q   <= 1'b0;
      exc_blk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_exc_q  <= main_exc_d;
      main_ds_q   <= main_ds_d;
      skid_data_q <= skid_data_d;
      skid_exc_q  <= skid_exc_d;
      skid_ds_q   <= skid_ds_d;
      exc_blk_q   <= exc_blk_d;
    end
  end

  // Stale register contents are masked so an empty stage presents zeros.
  assign out_data    = main_vld ? main_data_q : '0;
  assign out_exc     = main_vld ? main_exc_q  : '0;
  assign out_ds      = main_vld & main_ds_q;
  assign out_exc_any = |out_exc;

  always_comb begin
    out_exc_code = '0;
    for (int unsigned i = 0; i < EXC_W; i++) begin
      if (out_exc[EXC_W-1-i]) out_exc_code = EXC_CODE_W'(EXC_W - 1 - i);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the buffer.
module tb_pipe_stage_buf;
  localparam int DATA_W     = 160;
  localparam int EXC_W      = 5;
  localparam int EXC_CODE_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              ds;
  } entry_t;

  logic                  clk, rst_n;
  logic                  in_valid, in_ready, in_ds, flush;
  logic [DATA_W-1:0]     in_data;
  logic [EXC_W-1:0]      in_exc;
  logic                  out_valid, out_ready, out_ds, out_exc_any;
  logic [DATA_W-1:0]     out_data;
  logic [EXC_W-1:0]      out_exc;
  logic [EXC_CODE_W-1:0] out_exc_code;
  logic [1:0]            occupancy;

  int checks = 0;
  int errors = 0;

  entry_t model_q[$];
  bit     model_blk = 0;

  pipe_stage_buf #(
    .DATA_W    (DATA_W),
    .EXC_W     (EXC_W),
    .EXC_CODE_W(EXC_CODE_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_exc      (in_exc),
    .in_ds       (in_ds),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_exc     (out_exc),
    .out_ds      (out_ds),
    .out_exc_any (out_exc_any),
    .out_exc_code(out_exc_code),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    entry_t head;
    int     code;
    bit     exp_v;
    exp_v = (model_q.size() != 0);
    head  = exp_v ? model_q[0] : '0;
    code  = 0;
    for (int i = EXC_W - 1; i >= 0; i--) if (head.exc[i]) code = i;
    chk("out_valid", DATA_W'(out_valid), DATA_W'(exp_v));
    chk("in_ready", DATA_W'(in_ready), DATA_W'((model_q.size() < 2) || model_blk));
    chk("occupancy", DATA_W'(occupancy), DATA_W'(model_q.size()));
    chk("out_data", out_data, head.data);
    chk("out_exc", DATA_W'(out_exc), DATA_W'(head.exc));
    chk("out_ds", DATA_W'(out_ds), DATA_W'(head.ds));
    chk("out_exc_any", DATA_W'(out_exc_any), DATA_W'(head.exc != '0));
    chk("out_exc_code", DATA_W'(out_exc_code), DATA_W'(code));
  endtask

  // Called at the rising edge using the inputs that were applied for that cycle.
  task automatic model_edge();
    bit     in_x, out_x;
    entry_t e;
    in_x = in_valid && ((model_q.size() < 2) || model_blk);
    out_x = (model_q.size() != 0) && out_ready;
    if (flush) begin
      model_q.delete();
      model_blk = 0;
    end else begin
      if (out_x) void'(model_q.pop_front());
      if (in_x && !model_blk) begin
        e.data = in_data;
        e.exc  = in_exc;
        e.ds   = in_ds;
        model_q.push_back(e);
        if (in_exc != '0) model_blk = 1;
      end
    end
  endtask

  task automatic cyc(input bit iv, input logic [DATA_W-1:0] d, input logic [EXC_W-1:0] e,
                     input bit ds, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    in_exc    = e;
    in_ds     = ds;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    model_blk = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all();
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    rst_n = 1'b0; in_valid = 0; in_data = '0; in_exc = '0; in_ds = 0;
    flush = 0; out_ready = 0;
    #2 check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all();

    // Streaming 1..10
    for (int i = 1; i <= 10; i++) cyc(1, DATA_W'(i), '0, 0, 1, 0);
    chk("stream_last", out_data, DATA_W'(10));
    cyc(0, '0, '0, 0, 1, 0);

    // Backpressure 0xA, 0xB
    cyc(1, DATA_W'('hA), '0, 0, 0, 0);
    cyc(1, DATA_W'('hB), '0, 1, 0, 0);
    chk("bp_occ", DATA_W'(occupancy), DATA_W'(2));
    chk("bp_ready", DATA_W'(in_ready), DATA_W'(0));
    cyc(0, '0, '0, 0, 1, 0);
    chk("bp_second", out_data, DATA_W'('hB));
    cyc(0, '0, '0, 0, 1, 0);

    // Exception blocks later entries
    cyc(1, DATA_W'(1), 5'b00100, 0, 0, 0);
    chk("exc_code2", DATA_W'(out_exc_code), DATA_W'(2));
    cyc(1, DATA_W'(2), '0, 0, 0, 0);
    cyc(1, DATA_W'(3), '0, 0, 0, 0);
    chk("exc_occ", DATA_W'(occupancy), DATA_W'(1));
    cyc(0, '0, '0, 0, 1, 0);
    cyc(0, '0, '0, 0, 1, 0);
    chk("exc_drained", DATA_W'(out_valid), DATA_W'(0));

    // Flush with two held entries and exc_block set
    cyc(0, '0, '0, 0, 0, 1);
    cyc(1, DATA_W'('h10), '0, 0, 0, 0);
    cyc(1, DATA_W'('h11), 5'b00010, 0, 0, 0);
    chk("fl_occ2", DATA_W'(occupancy), DATA_W'(2));
    chk("fl_ready_blk", DATA_W'(in_ready), DATA_W'(1));
    cyc(1, DATA_W'(7), '0, 0, 0, 1);
    chk("fl_occ0", DATA_W'(occupancy), DATA_W'(0));
    cyc(1, DATA_W'(8), '0, 0, 1, 0);
    chk("fl_next", out_data, DATA_W'(8));
    cyc(0, '0, '0, 0, 1, 0);

    // Priority encode
    cyc(1, DATA_W'('h20), 5'b11000, 0, 0, 0);
    chk("pe_code3", DATA_W'(out_exc_code), DATA_W'(3));
    cyc(0, '0, '0, 0, 0, 1);
    cyc(1, DATA_W'('h21), 5'b00001, 0, 0, 0);
    chk("pe_code0", DATA_W'(out_exc_code), DATA_W'(0));
    chk("pe_any", DATA_W'(out_exc_any), DATA_W'(1));
    cyc(0, '0, '0, 0, 0, 1);

    // Async reset while full
    cyc(1, DATA_W'('h30), '0, 0, 0, 0);
    cyc(1, DATA_W'('h31), '0, 0, 0, 0);
    async_reset();
    chk("ar_occ", DATA_W'(occupancy), DATA_W'(0));
    cyc(1, DATA_W'('h32), '0, 0, 1, 0);
    chk("ar_first", out_data, DATA_W'('h32));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      cyc($urandom_range(0, 3) != 0, rd,
          ($urandom_range(0, 19) == 0) ? EXC_W'($urandom_range(1, 31)) : '0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0);
      if (n % 400 == 399) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 160, SHALL set the payload width in bits.
REQ-002 Parameter EXC_W, default 5, SHALL set the number of exception flag bits.
REQ-003 Parameter EXC_CODE_W, default 3, SHALL set the encoded exception width; 2^EXC_CODE_W >= EXC_W is required.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 in_valid  in  1  upstream holds a valid entry.
REQ-007 in_ready  out  1  block can take an entry this cycle.
REQ-008 in_data  in  DATA_W  entry payload (PC, inst, ALU results, control).
REQ-009 in_exc  in  EXC_W  per-entry exception flags (bit 0 = highest priority).
REQ-010 in_ds  in  1  entry is in a branch delay slot.
REQ-011 flush  in  1  kill all held entries and clear the exception block.
REQ-012 out_valid  out  1  head entry valid.
REQ-013 out_ready  in  1  downstream accepts the head entry.
REQ-014 out_data / out_exc / out_ds  out  DATA_W / EXC_W / 1  head entry fields.
REQ-015 out_exc_any  out  1  OR of out_exc.
REQ-016 out_exc_code  out  EXC_CODE_W  index of the lowest set out_exc bit; 0 when none is set.
REQ-017 occupancy  out  2  number of held entries (0 to 2).

Function
REQ-018 Storage SHALL be a 2-entry skid buffer: a main register (head) and a skid register, each holding data, exc, ds and a valid bit.
REQ-019 in_ready SHALL equal NOT skid_valid, driven directly from a register with no combinational path from out_ready.
REQ-020 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-021 State is defined by occupancy: EMPTY (0), ONE (1), TWO (2).
REQ-022 EMPTY + input transfer SHALL load the main register and move to ONE, so the latency from input to out_valid is 1 cycle.
REQ-023 ONE + input transfer + no output transfer SHALL load the skid register and move to TWO.
REQ-024 ONE + input transfer + output transfer SHALL load the main register and stay in ONE.
REQ-025 ONE + output transfer only SHALL move to EMPTY.
REQ-026 TWO + output transfer SHALL move skid to main and go to ONE; no input transfer is possible in TWO.
REQ-027 Entries SHALL leave in arrival order; none SHALL be duplicated or dropped except by REQ-028 and REQ-029.
REQ-028 flush=1 SHALL clear both valid bits and exc_block at the next edge, overriding every other transfer in that cycle.
REQ-029 The input entry accepted in a flush cycle SHALL be discarded.
REQ-030 When an input transfer has any in_exc bit set, exc_block SHALL set at that edge.
REQ-031 While exc_block=1, in_ready SHALL be 1 and every input transfer SHALL be discarded, with no state change beyond the discard.
REQ-032 exc_block SHALL clear only on flush or reset.
REQ-033 out_data, out_exc and out_ds SHALL be 0 whenever out_valid=0.
REQ-034 out_exc_any and out_exc_code SHALL be combinational functions of out_exc.
REQ-035 Held entries SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-036 rst_n=0 SHALL asynchronously clear every valid bit, exc_block and all data/exc/ds registers.
REQ-037 During reset, out_valid=0, in_ready=1, occupancy=0, out_data=0, out_exc=0, out_ds=0, out_exc_any=0 and out_exc_code=0.
REQ-038 Reset asserted mid-transfer SHALL discard all entries; the first accepted entry after release SHALL be the first one output.

Verification
REQ-039 Streaming: in_valid=1 and out_ready=1 for 10 cycles with data 1..10 -> out_valid is 1 from cycle 1, data is 1..10 in order, occupancy stays 1, in_ready stays 1.
REQ-040 Backpressure: out_ready=0 while data 0xA and then 0xB are sent -> occupancy 2 and in_ready=0; set out_ready=1 -> 0xA then 0xB come out and in_ready returns to 1 one cycle later.
REQ-041 Exception: send 0x1 with in_exc=5'b00100, then 0x2 and 0x3 clean -> only 0x1 comes out, with out_exc_any=1 and out_exc_code=2; 0x2 and 0x3 are accepted and dropped.
REQ-042 Flush: with occupancy 2 and exc_block=1, assert flush for one cycle with in_valid=1 and data 0x7 -> occupancy 0, 0x7 discarded, and the next entry 0x8 comes out normally.
REQ-043 Async reset: assert rst_n=0 between clock edges with occupancy 2 -> out_valid=0 and occupancy=0 at once, with no clock edge needed.
REQ-044 Priority encode: in_exc=5'b11000 -> out_exc_code=3; in_exc=5'b00001 -> out_exc_code=0 and out_exc_any=1.
